// File: rtl/ascii_conv_pkg.sv
// Shared types and constants for the ASCII conversion scheduler.
package ascii_conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        BURST,
        WAIT_BUSY,
        SETTLE,
        RESULT
    } sched_state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= ASCII_ZERO) && (c <= ASCII_NINE);
    endfunction

endpackage

// File: rtl/ascii_conv_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or after ptr.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [PW-1:0] idx;
    int            s;

    // Walk from the farthest offset back to ptr so the nearest requester wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        s   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            s = int'(ptr) + i;
            if (s >= N) s = s - N;
            idx = s[PW-1:0];
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ascii_conv_scheduler.sv
// Time-shares one ASCII-to-binary converter between N_REQ character streams, one string per grant.
module ascii_conv_scheduler
    import ascii_conv_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DIGITS     = 8,
    parameter int RESULT_LAT = 1   // must be >= 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req_valid_i,
    input  logic [8*N_REQ-1:0]            req_char_i,
    input  logic [N_REQ-1:0]              req_last_i,
    output logic [N_REQ-1:0]              req_ready_o,
    output logic [7:0]                    conv_char_o,
    output logic                          conv_valid_o,
    input  logic                          conv_busy_i,
    input  logic [4*DIGITS-1:0]           conv_data_i,
    output logic                          res_valid_o,
    input  logic                          res_ready_i,
    output logic [4*DIGITS-1:0]           res_data_o,
    output logic [$clog2(N_REQ)-1:0]      res_chan_o,
    output logic [$clog2(DIGITS+1)-1:0]   res_len_o,
    output logic                          res_err_o
);

    localparam int CW   = $clog2(N_REQ);
    localparam int LW   = $clog2(DIGITS + 1);
    localparam int BW   = $clog2(DIGITS);
    localparam int LATW = $clog2(RESULT_LAT + 1);
    localparam logic [LW-1:0]   DIG_MAX  = LW'(DIGITS);
    localparam logic [LATW-1:0] LAT_LAST = LATW'(RESULT_LAT - 1);

    sched_state_t             state, nxt;
    logic [CW-1:0]            g, rr_ptr, gidx;
    logic [N_REQ-1:0]         gnt, rdy;
    logic [N_REQ-1:0][7:0]    chars;
    logic [DIGITS-1:0][7:0]   char_buf;
    logic [LW-1:0]            cnt;
    logic                     err;
    logic [BW-1:0]            bidx;
    logic                     seen_busy;
    logic [LATW-1:0]          lat_cnt;
    logic [7:0]               in_char;
    logic                     acc, last_acc, room, burst_done, busy_fall, settle_done;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req (req_valid_i),
        .ptr (rr_ptr),
        .gnt (gnt)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < N_REQ; i++)
            if (gnt[i]) gidx = CW'(i);
    end

    assign chars       = req_char_i;
    assign in_char     = chars[g];
    assign acc         = (state == COLLECT) && req_valid_i[g] && rdy[g];
    assign last_acc    = acc && req_last_i[g];
    assign room        = cnt < DIG_MAX;
    assign burst_done  = (state == BURST) && (LW'(bidx) == cnt - LW'(1));
    assign busy_fall   = (state == WAIT_BUSY) && seen_busy && !conv_busy_i;
    assign settle_done = (state == SETTLE) && (lat_cnt == LAT_LAST);

    assign req_ready_o  = rdy;
    assign conv_valid_o = (state == BURST);
    assign conv_char_o  = (state == BURST) ? char_buf[bidx] : 8'h00;
    assign res_valid_o  = (state == RESULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:      if (|req_valid_i) nxt = COLLECT;
            COLLECT:   if (last_acc)     nxt = BURST;
            BURST:     if (burst_done)   nxt = WAIT_BUSY;
            WAIT_BUSY: if (busy_fall)    nxt = SETTLE;
            SETTLE:    if (settle_done)  nxt = RESULT;
            RESULT:    if (res_ready_i)  nxt = IDLE;
            default:                     nxt = IDLE;
        endcase
    end

    // Character storage carries no reset; cnt alone decides what is valid.
    always_ff @(posedge clk) begin
        if (acc && room)
            char_buf[cnt[BW-1:0]] <= is_digit(in_char) ? in_char : ASCII_ZERO;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g          <= '0;
            rr_ptr     <= '0;
            rdy        <= '0;
            cnt        <= '0;
            err        <= 1'b0;
            bidx       <= '0;
            seen_busy  <= 1'b0;
            lat_cnt    <= '0;
            res_data_o <= '0;
            res_chan_o <= '0;
            res_len_o  <= '0;
            res_err_o  <= 1'b0;
        end else begin
            if (state == IDLE && |req_valid_i) begin
                g   <= gidx;
                rdy <= gnt;
            end
            if (acc) begin
                if (room) cnt <= cnt + LW'(1);
                if (!room || !is_digit(in_char)) err <= 1'b1;
            end
            if (last_acc) rdy <= '0;
            if (state == BURST) bidx <= burst_done ? '0 : bidx + BW'(1);
            // Busy must be seen high before its fall counts, even if low on entry.
            if (state == WAIT_BUSY && conv_busy_i) seen_busy <= 1'b1;
            if (busy_fall) seen_busy <= 1'b0;
            if (state == SETTLE) begin
                lat_cnt <= settle_done ? '0 : lat_cnt + LATW'(1);
                if (settle_done) begin
                    res_data_o <= conv_data_i;
                    res_chan_o <= g;
                    res_len_o  <= cnt;
                    res_err_o  <= err;
                end
            end
            if (state == RESULT && res_ready_i) begin
                rr_ptr <= (g == CW'(N_REQ - 1)) ? '0 : g + CW'(1);
                cnt    <= '0;
                err    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ascii_conv_scheduler.sv
// Randomized bench for ascii_conv_scheduler with a string-level reference model and converter responder.
module tb_ascii_conv_scheduler;

    localparam int N  = 4;
    localparam int D  = 8;
    localparam int RL = 1;
    localparam int CW = $clog2(N);
    localparam int LW = $clog2(D + 1);

    typedef struct packed { logic [95:0] b; logic [7:0] n; } str_t;
    typedef struct packed { logic [63:0] b; logic [7:0] n; } burst_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid_i, req_last_i, req_ready_o;
    logic [8*N-1:0]    req_char_i;
    logic [7:0]        conv_char_o;
    logic              conv_valid_o, conv_busy_i;
    logic [4*D-1:0]    conv_data_i, res_data_o;
    logic              res_valid_o, res_ready_i, res_err_o;
    logic [CW-1:0]     res_chan_o;
    logic [LW-1:0]     res_len_o;

    logic              v [N];
    logic [7:0]        cv[N];
    logic              lv[N];

    str_t   sq[N][$];
    int     gq[$];
    int     ord_log[$];
    burst_t bq[$];
    logic [31:0] conv_last;
    int     n_cmp = 0, n_bad = 0;
    int     rdy_mode = 0;
    bit     holding = 0;

    ascii_conv_scheduler #(.N_REQ(N), .DIGITS(D), .RESULT_LAT(RL)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_char_i(req_char_i), .req_last_i(req_last_i),
        .req_ready_o(req_ready_o),
        .conv_char_o(conv_char_o), .conv_valid_o(conv_valid_o),
        .conv_busy_i(conv_busy_i), .conv_data_i(conv_data_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_data_o(res_data_o), .res_chan_o(res_chan_o),
        .res_len_o(res_len_o), .res_err_o(res_err_o)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_valid_i = '0;
        req_last_i  = '0;
        req_char_i  = '0;
        for (int k = 0; k < N; k++) begin
            req_valid_i[k]       = v[k];
            req_last_i[k]        = lv[k];
            req_char_i[8*k +: 8] = cv[k];
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic str_t mk(input string s);
        str_t r = '0;
        r.n = 8'(s.len());
        for (int i = 0; i < s.len(); i++) r.b[8*i +: 8] = s[i];
        return r;
    endfunction

    function automatic str_t rnd_str();
        str_t r = '0;
        int   n = $urandom_range(1, 10);
        r.n = 8'(n);
        for (int i = 0; i < n; i++)
            r.b[8*i +: 8] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(32, 126))
                                                        : 8'h30 + 8'($urandom_range(0, 9));
        return r;
    endfunction

    // String-level rules: first D characters are sent, non-digits become '0', overflow or non-digit flags err.
    function automatic void expect_of(input str_t s, output logic [63:0] eb, output int len, output bit e);
        logic [7:0] c;
        bit dig;
        eb  = '0;
        len = (int'(s.n) > D) ? D : int'(s.n);
        e   = int'(s.n) > D;
        for (int i = 0; i < int'(s.n); i++) begin
            c   = s.b[8*i +: 8];
            dig = (c >= 8'h30) && (c <= 8'h39);
            if (!dig) e = 1'b1;
            if (i < D) eb[8*i +: 8] = dig ? c : 8'h30;
        end
    endfunction

    task automatic send_str(input int c, input str_t s, input int maxgap, input int pregap, output int nacc);
        int t, gp;
        nacc = 0;
        repeat (pregap) @(negedge clk);
        sq[c].push_back(s);
        for (int i = 0; i < int'(s.n); i++) begin
            v[c]  = 1'b1;
            cv[c] = s.b[8*i +: 8];
            lv[c] = (i == int'(s.n) - 1);
            t = 0;
            while (!req_ready_o[c] && t < 3000) begin @(negedge clk); t++; end
            if (t >= 3000) begin
                chk($sformatf("accept_timeout_ch%0d", c), 64'(0), 64'(1));
                v[c] = 1'b0; lv[c] = 1'b0;
                return;
            end
            @(negedge clk);
            nacc++;
            if (i == 0) begin gq.push_back(c); ord_log.push_back(c); end
            if (lv[c]) begin
                v[c] = 1'b0; lv[c] = 1'b0;
                #1;
                chk("ready_fall_after_last", 64'(req_ready_o[c]), 64'(0));
                chk("burst_start_latency", 64'(conv_valid_o), 64'(1));
            end else if (maxgap > 0) begin
                gp = $urandom_range(0, maxgap);
                if (gp > 0) begin v[c] = 1'b0; repeat (gp) @(negedge clk); end
            end
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((gq.size() != 0 || holding) && t < 5000) begin @(negedge clk); t++; end
        if (t >= 5000) chk("drain_timeout", 64'(0), 64'(1));
        repeat (3) @(negedge clk);
    endtask

    task automatic ch_rand(input int c);
        int na;
        for (int j = 0; j < 5; j++) send_str(c, rnd_str(), 3, $urandom_range(0, 4), na);
    endtask

    // Converter responder: records each burst, then busy pulse after 0..2 idle cycles, data final on busy fall.
    initial begin
        logic [63:0] cur;
        int cn, d, h;
        bit inb;
        cur = '0; cn = 0; inb = 0;
        conv_busy_i = 1'b0; conv_data_i = '0; conv_last = '0;
        forever begin
            @(negedge clk); #1;
            if (conv_valid_o) begin
                if (cn < 8) cur[8*cn +: 8] = conv_char_o;
                cn++; inb = 1;
            end else if (inb) begin
                inb = 0;
                bq.push_back('{cur, 8'(cn)});
                cur = '0; cn = 0;
                d = $urandom_range(0, 2);
                repeat (d) @(negedge clk);
                conv_busy_i = 1'b1;
                conv_data_i = $urandom;
                h = $urandom_range(1, 4);
                repeat (h) @(negedge clk);
                conv_busy_i = 1'b0;
                conv_data_i = $urandom;
                conv_last   = conv_data_i;
            end
        end
    end

    initial begin
        res_ready_i = 1'b1;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                1:       res_ready_i = 1'($urandom_range(0, 1));
                2:       res_ready_i = 1'b0;
                default: res_ready_i = 1'b1;
            endcase
        end
    end

    // Result monitor: scoreboard compare on first valid cycle, stability while held.
    initial begin
        str_t s; burst_t b; logic [63:0] eb, hd, hm; int el, c; bit ee;
        forever begin
            @(negedge clk); #1;
            if (!rst_n) begin holding = 0; continue; end
            chk("ready_onehot0", 64'($onehot0(req_ready_o)), 64'(1));
            if (res_valid_o) begin
                chk("no_grant_during_result", 64'(req_ready_o), 64'(0));
                if (!holding) begin
                    if (gq.size() == 0) chk("unexpected_result", 64'(1), 64'(0));
                    else begin
                        c = gq.pop_front();
                        s = sq[c].pop_front();
                        expect_of(s, eb, el, ee);
                        if (bq.size() == 0) begin chk("burst_missing", 64'(0), 64'(1)); b = '0; end
                        else b = bq.pop_front();
                        chk("res_chan", 64'(res_chan_o), 64'(c));
                        chk("res_len", 64'(res_len_o), 64'(el));
                        chk("res_err", 64'(res_err_o), 64'(ee));
                        chk("res_data", 64'(res_data_o), 64'(conv_last));
                        chk("burst_len", 64'(b.n), 64'(el));
                        chk("burst_chars", b.b, eb);
                    end
                    hd = 64'(res_data_o);
                    hm = 64'({res_chan_o, res_len_o, res_err_o});
                    holding = 1;
                end else begin
                    chk("hold_data", 64'(res_data_o), hd);
                    chk("hold_meta", 64'({res_chan_o, res_len_o, res_err_o}), hm);
                end
                if (res_ready_i) holding = 0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int na, base, t;
        int exp_ord[5] = '{0, 1, 2, 3, 0};
        for (int k = 0; k < N; k++) begin v[k] = 1'b0; cv[k] = 8'h00; lv[k] = 1'b0; end
        rst_n = 1'b0;
        repeat (2) @(negedge clk); #1;
        chk("rst_req_ready", 64'(req_ready_o), 64'(0));
        chk("rst_conv_valid", 64'(conv_valid_o), 64'(0));
        chk("rst_conv_char", 64'(conv_char_o), 64'(0));
        chk("rst_res_valid", 64'(res_valid_o), 64'(0));
        chk("rst_res_fields", 64'({res_data_o, res_chan_o, res_len_o, res_err_o}), 64'(0));
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        send_str(0, mk("1234"), 0, 0, na);
        drain();
        send_str(2, mk("7"), 0, 3, na);
        drain();
        send_str(3, mk("9"), 0, 0, na);
        drain();

        base = ord_log.size();
        fork
            begin send_str(0, mk("11"), 0, 0, na); send_str(0, mk("55"), 0, 0, na); end
            send_str(1, mk("22"), 0, 0, na);
            send_str(2, mk("33"), 0, 0, na);
            send_str(3, mk("44"), 0, 0, na);
        join
        drain();
        for (int k = 0; k < 5; k++)
            chk($sformatf("rr_order_%0d", k),
                64'((ord_log.size() > base + k) ? ord_log[base + k] : -1), 64'(exp_ord[k]));

        send_str(1, mk("1234567890"), 0, 0, na);
        chk("overflow_beats_accepted", 64'(na), 64'(10));
        drain();
        send_str(3, mk("12A4"), 0, 0, na);
        drain();

        rdy_mode = 2;
        fork
            send_str(1, mk("55"), 0, 0, na);
            send_str(3, mk("678"), 0, 0, na);
            begin
                t = 0;
                while (!res_valid_o && t < 500) begin @(negedge clk); t++; end
                if (t >= 500) chk("hold_wait_timeout", 64'(0), 64'(1));
                repeat (5) @(negedge clk);
                rdy_mode = 0;
            end
        join
        drain();

        rdy_mode = 1;
        fork
            ch_rand(0);
            ch_rand(1);
            ch_rand(2);
            ch_rand(3);
        join
        drain();
        rdy_mode = 0;
        drain();

        send_str(1, mk("5678"), 0, 0, na);
        drain();
        send_str(1, mk("4321"), 0, 0, na);
        #1 rst_n = 1'b0;
        #1;
        chk("reset_drops_valid", 64'(conv_valid_o), 64'(0));
        chk("reset_no_result", 64'(res_valid_o), 64'(0));
        repeat (20) @(negedge clk);
        gq.delete(); bq.delete(); sq[1].delete();
        rst_n = 1'b1;
        base = ord_log.size();
        fork
            send_str(0, mk("3"), 0, 0, na);
            send_str(2, mk("4"), 0, 0, na);
        join
        drain();
        chk("post_reset_first_grant", 64'((ord_log.size() > base) ? ord_log[base] : -1), 64'(0));
        chk("no_stray_bursts", 64'(bq.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ascii_conv_scheduler.md
# ascii_conv_scheduler

Shares one `ascii_to_binary_converter` instance between `N_REQ` ASCII character streams. For each granted requester it buffers one decimal string, then replays it to the converter as a single contiguous valid burst. It waits for the conversion to complete and returns the binary result, tagged with the requester index, over a valid/ready result port. Requesters are served round-robin, one string per grant.

## Interface
- `N_REQ`, 4: number of requester channels (2..16).
- `DIGITS`, 8: maximum digits per string; must equal the converter's `DIGITS_LENGTH`.
- `RESULT_LAT`, 1: cycles after the converter's busy falls until its data output is stable.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid_i`  in  N_REQ  per-channel character valid.
- `req_char_i`  in  8*N_REQ  per-channel ASCII character; channel k occupies bits [8k+7:8k].
- `req_last_i`  in  N_REQ  marks the final character of a string.
- `req_ready_o`  out  N_REQ  per-channel character accept; one-hot or zero.
- `conv_char_o`  out  8  character to the converter.
- `conv_valid_o`  out  1  converter valid; high for exactly one contiguous burst per string.
- `conv_busy_i`  in  1  converter busy.
- `conv_data_i`  in  4*DIGITS  converter binary output.
- `res_valid_o`  out  1  result valid.
- `res_ready_i`  in  1  result accept.
- `res_data_o`  out  4*DIGITS  captured converter result.
- `res_chan_o`  out  $clog2(N_REQ)  index of the requester that owned the string.
- `res_len_o`  out  $clog2(DIGITS+1)  number of digits sent to the converter (1..DIGITS).
- `res_err_o`  out  1  string contained a non-digit or more than DIGITS characters.

## Operation
- FSM states: IDLE, COLLECT, BURST, WAIT_BUSY, SETTLE, RESULT.
- **IDLE.** If any `req_valid_i` is high, the round-robin arbiter picks a channel, starting from pointer `rr_ptr`. The grant is registered and the FSM moves to COLLECT. Nothing is accepted in this cycle.
- **COLLECT.**
  - `req_ready_o[g]` is high. A beat is accepted when valid and ready are both high.
  - Gaps in `req_valid_i` are tolerated.
  - Each accepted character is stored in buffer slot `cnt` while `cnt < DIGITS`. Characters accepted beyond that are dropped and set `err`.
  - A character outside 8'h30..8'h39 is stored as 8'h30 and sets `err`.
  - When the accepted beat has `req_last_i` set, the FSM moves to BURST.
- **BURST.**
  - `conv_valid_o` is high for exactly `cnt` consecutive cycles.
  - `conv_char_o` presents slots 0..cnt-1 in order, so the most-significant digit goes first.
  - After the last slot the FSM moves to WAIT_BUSY.
- **WAIT_BUSY.** The FSM waits for `conv_busy_i` to go high and then low. The wait is required even if busy is already low on entry. On the falling edge of busy, the FSM moves to SETTLE.
- **SETTLE.** The FSM waits `RESULT_LAT` cycles. It then loads `res_data_o` from `conv_data_i` and moves to RESULT.
- **RESULT.**
  - `res_valid_o` is high and all `res_*` outputs are held stable until `res_ready_i` is high.
  - On that handshake: `rr_ptr` becomes g+1 mod N_REQ, `err` and `cnt` clear, and the FSM returns to IDLE.
- Arbitration is purely round-robin with no priorities. A channel whose valid drops before it is granted simply loses its turn.

## Timing
- Reset values:
  - all outputs are 0;
  - `rr_ptr` is 0;
  - FSM is in IDLE;
  - buffer contents are don't-care.
- Asynchronous reset in any state aborts the string immediately. `conv_valid_o` drops in the same cycle the reset asserts, and no partial result is emitted.
- `req_ready_o` is registered. It goes high the cycle after the grant and falls the cycle after the last beat is accepted.
- From the last beat accepted to `conv_valid_o` rising: 1 cycle.
- Result latency after burst end = converter busy time + `RESULT_LAT` + 1 cycle.
- If `res_ready_i` is already high when `res_valid_o` rises, the result is held for exactly one cycle. The next grant can be made no earlier than the following cycle.
- Only one string is in flight at a time. Other channels see `req_ready_o` at 0 throughout.
- A single-character string (last on the first beat) is legal and produces a 1-cycle burst.

## Structure
- Package `ascii_conv_pkg`:
  - `sched_state_t` enum;
  - `ASCII_ZERO` = 8'h30;
  - `ASCII_NINE` = 8'h39.
- Sub-module `rr_arbiter #(N)`: combinational one-hot grant from a request vector and a pointer. It is instantiated once.
- The converter is not instantiated inside this block. The top level wires the `conv_*` ports to it.

## Test plan
- Channel 0 sends "1234" with `last` on '4' → a 4-cycle `conv_valid_o` burst carrying 31,32,33,34, then `res_chan_o`=0, `res_len_o`=4, `res_err_o`=0, and `res_data_o` equal to `conv_data_i` at capture.
- Channel 2 sends "7", pausing 3 cycles between valid assertions → one `conv_valid_o` pulse carrying 8'h37 and `res_len_o`=1.
- All 4 channels request continuously → grants in order 0,1,2,3,0, each with the correct `res_chan_o`.
- A 10-character string with `DIGITS`=8 → 8-cycle burst, `res_len_o`=8, `res_err_o`=1, and all 10 beats accepted.
- "12A4" → burst carries 31,32,30,34 and `res_err_o`=1. In a separate run, hold `res_ready_i` low for 5 cycles → `res_valid_o` and `res_data_o` stay stable, and no new grant is made.
- Assert `rst_n` low during BURST → `conv_valid_o`=0 immediately, no `res_valid_o`, and the next grant starts from channel 0.
